// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART TX arbiter: byte width, FSM encodings and
// the round-robin scan helper.
package uart_tx_arbiter_pkg;
    localparam int UART_BYTE_W = 8;

    typedef enum logic [0:0] {A_IDLE, A_LOCK} arb_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_WAITHI, T_WAITLO} tx_state_t;

    // i-th candidate when scanning round-robin from the slot after rr
    function automatic int rr_index(input int rr, input int i, input int n);
        return (rr + 1 + i) % n;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the transmitter start/busy handshake.
// master = requesters and UART TX side, slave = the arbiter.
interface uart_tx_arbiter_if #(parameter int NREQ = 4);
    import uart_tx_arbiter_pkg::*;

    logic [NREQ-1:0]                  req_valid;
    logic [NREQ-1:0][UART_BYTE_W-1:0] req_data;
    logic [NREQ-1:0]                  req_last;
    logic [NREQ-1:0]                  req_ready;
    logic                             tx_start;
    logic [UART_BYTE_W-1:0]           tx_data;
    logic                             tx_busy;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data
    );
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_fifo.sv
// Small synchronous byte FIFO. Push is ignored when full, pop when empty.
module uart_byte_fifo
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [UART_BYTE_W-1:0] din,
    input  logic                   pop,
    output logic [UART_BYTE_W-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [UART_BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   push_en;
    logic                   pop_en;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // storage array needs no reset; only pointers/level define contents
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one async transmitter among NREQ byte-stream requesters.
// Round-robin grant locked per packet, byte FIFO, start/busy sequencer.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int DEPTH        = 8,
    parameter int LOCK_TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    resetn,
    uart_tx_arbiter_if.slave        bus,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    locked,
    output logic [$clog2(DEPTH):0]  fifo_level
);
    localparam int GW      = $clog2(NREQ);
    localparam int TMO_MAX = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;
    localparam int TW      = (TMO_MAX > 0) ? $clog2(TMO_MAX + 1) : 1;

    arb_state_t             arb_state;
    tx_state_t              tx_state;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          pick;
    logic                   pick_vld;
    logic [TW-1:0]          tmo_cnt;
    logic                   wait_cnt;
    logic [NREQ-1:0]        ready;
    logic                   accept;
    logic                   acc_last;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic [UART_BYTE_W-1:0] head;
    logic                   start_q;
    logic [UART_BYTE_W-1:0] data_q;

    // only the locked requester sees ready, gated by registered FIFO level
    always_comb begin
        ready = '0;
        if (arb_state == A_LOCK) ready[grant_id] = !fifo_full;
    end

    assign accept        = bus.req_valid[grant_id] && ready[grant_id];
    assign acc_last      = accept && bus.req_last[grant_id];
    assign bus.req_ready = ready;
    assign bus.tx_start  = start_q;
    assign bus.tx_data   = data_q;
    assign pop           = (tx_state == T_IDLE) && !fifo_empty && !bus.tx_busy;

    // first valid requester scanning from the slot after the last winner
    always_comb begin
        logic [GW-1:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = GW'(rr_index(int'(rr_ptr), i, NREQ));
            if (!pick_vld && bus.req_valid[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .din    (bus.req_data[grant_id]),
        .pop    (pop),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // arbiter: registered grant, held until last byte or idle timeout;
    // FIFO-full stalls are not idleness and do not advance the timeout
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arb_state <= A_IDLE;
            grant_id  <= '0;
            locked    <= 1'b0;
            rr_ptr    <= GW'(NREQ - 1);
            tmo_cnt   <= '0;
        end else begin
            case (arb_state)
                A_IDLE: begin
                    tmo_cnt <= '0;
                    if (pick_vld) begin
                        grant_id  <= pick;
                        locked    <= 1'b1;
                        arb_state <= A_LOCK;
                    end
                end
                A_LOCK: begin
                    if (accept) begin
                        tmo_cnt <= '0;
                        if (acc_last) begin
                            locked    <= 1'b0;
                            rr_ptr    <= grant_id;
                            arb_state <= A_IDLE;
                        end
                    end else if (LOCK_TIMEOUT != 0 && !fifo_full) begin
                        if (tmo_cnt == TW'(TMO_MAX)) begin
                            locked    <= 1'b0;
                            rr_ptr    <= grant_id;
                            arb_state <= A_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                default: arb_state <= A_IDLE;
            endcase
        end
    end

    // TX sequencer: one-cycle start, then follow busy high and low; a start
    // the transmitter never acknowledges is given up after two cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state <= T_IDLE;
            start_q  <= 1'b0;
            data_q   <= '0;
            wait_cnt <= 1'b0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (pop) begin
                        data_q   <= head;
                        start_q  <= 1'b1;
                        tx_state <= T_START;
                    end
                end
                T_START: begin
                    start_q  <= 1'b0;
                    wait_cnt <= 1'b0;
                    tx_state <= T_WAITHI;
                end
                T_WAITHI: begin
                    if (bus.tx_busy)   tx_state <= T_WAITLO;
                    else if (wait_cnt) tx_state <= T_IDLE;
                    else               wait_cnt <= 1'b1;
                end
                T_WAITLO: begin
                    if (!bus.tx_busy) tx_state <= T_IDLE;
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a fast behavioural transmitter.
module tb_uart_tx_arbiter;
    localparam int NREQ  = 4;
    localparam int DEPTH = 4;
    localparam int LTMO  = 16;
    localparam int FRAME = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [1:0] grant_id;
    logic       locked;
    logic [2:0] fifo_level;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .LOCK_TIMEOUT(LTMO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .grant_id   (grant_id),
        .locked     (locked),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // transmitter model and monitors
    int         busy_cnt = 0;
    logic       busy_model = 1'b0;
    logic       busy_force = 1'b0;
    logic       busy_prev = 1'b0;
    logic       start_prev = 1'b0;
    logic       locked_prev = 1'b0;
    int         pulse_err = 0;
    int         busy_err = 0;
    int         rdy_err = 0;
    int         lock_err = 0;
    bit         chk_r1 = 1'b0;
    logic [7:0] tx_log [$];
    logic [1:0] grant_log [$];
    logic [8:0] sq [NREQ][$];

    assign bus.tx_busy = busy_model | busy_force;

    always @(negedge clk) begin
        if (bus.tx_start) begin
            if (start_prev) pulse_err++;
            if (busy_prev) busy_err++;
            tx_log.push_back(bus.tx_data);
            busy_cnt = FRAME;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        busy_model  = (busy_cnt != 0);
        busy_prev   = busy_model | busy_force;
        start_prev  = bus.tx_start;
        if (locked && !locked_prev) grant_log.push_back(grant_id);
        locked_prev = locked;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_inputs();
        for (int i = 0; i < NREQ; i++) sq[i].delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        tx_log.delete();
        grant_log.delete();
        pulse_err = 0; busy_err = 0; rdy_err = 0; lock_err = 0;
        chk_r1 = 1'b0;
    endtask

    // drive queued bytes per requester; optionally stop once fully drained
    task automatic run_streams(input int ncyc, input bit until_done, output bit done);
        int idle_cnt;
        bit acc_last;
        idle_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (sq[i].size() > 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_data[i]  = sq[i][0][7:0];
                    bus.req_last[i]  = sq[i][0][8];
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_data[i]  = '0;
                    bus.req_last[i]  = 1'b0;
                end
            end
            #1;
            if ($countones(bus.req_ready) > 1) rdy_err++;
            if (chk_r1 && bus.req_ready[1] && sq[0].size() != 0) rdy_err++;
            acc_last = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    if (sq[i][0][8]) acc_last = 1'b1;
                    void'(sq[i].pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (acc_last && locked) lock_err++;
            if (until_done && sq[0].size() == 0 && sq[1].size() == 0 && sq[2].size() == 0 &&
                sq[3].size() == 0 && fifo_level == 0 && !bus.tx_busy) begin
                idle_cnt++;
                if (idle_cnt > 4) begin
                    done = 1'b1;
                    break;
                end
            end else begin
                idle_cnt = 0;
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        #2;
        cmp_cnt++; if (bus.req_ready !== 4'b0) begin err_cnt++; $display("FAIL rst_ready got %b want 0000", bus.req_ready); end
        cmp_cnt++; if (bus.tx_start !== 1'b0) begin err_cnt++; $display("FAIL rst_tx_start got %b want 0", bus.tx_start); end
        cmp_cnt++; if (bus.tx_data !== 8'h00) begin err_cnt++; $display("FAIL rst_tx_data got %h want 00", bus.tx_data); end
        cmp_cnt++; if (grant_id !== 2'd0) begin err_cnt++; $display("FAIL rst_grant got %0d want 0", grant_id); end
        cmp_cnt++; if (locked !== 1'b0) begin err_cnt++; $display("FAIL rst_locked got %b want 0", locked); end
        cmp_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL rst_level got %0d want 0", fifo_level); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_single_packet();
        bit d;
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        do_reset();
        sq[0] = '{9'h041, 9'h042, 9'h143};
        run_streams(2000, 1'b1, d);
        cmp_cnt++; if (d !== 1'b1) begin err_cnt++; $display("FAIL t1_drain got %b want 1", d); end
        cmp_cnt++; if (tx_log.size() !== 3) begin err_cnt++; $display("FAIL t1_count got %0d want 3", tx_log.size()); end
        for (int k = 0; k < 3; k++) begin
            cmp_cnt++;
            if (k >= tx_log.size() || tx_log[k] !== exp[k]) begin
                err_cnt++; $display("FAIL t1_byte%0d got %h want %h", k, (k < tx_log.size()) ? tx_log[k] : 8'hxx, exp[k]);
            end
        end
        cmp_cnt++; if (pulse_err !== 0) begin err_cnt++; $display("FAIL t1_pulse_width got %0d want 0", pulse_err); end
        cmp_cnt++; if (busy_err !== 0) begin err_cnt++; $display("FAIL t1_start_while_busy got %0d want 0", busy_err); end
        cmp_cnt++; if (lock_err !== 0) begin err_cnt++; $display("FAIL t1_lock_after_last got %0d want 0", lock_err); end
        cmp_cnt++; if (locked !== 1'b0) begin err_cnt++; $display("FAIL t1_locked_end got %b want 0", locked); end
    endtask

    task automatic test_packet_lock();
        bit d;
        logic [7:0] exp [4] = '{8'h10, 8'h11, 8'h20, 8'h21};
        do_reset();
        chk_r1 = 1'b1;
        sq[0] = '{9'h010, 9'h111};
        sq[1] = '{9'h020, 9'h121};
        run_streams(2000, 1'b1, d);
        cmp_cnt++; if (d !== 1'b1) begin err_cnt++; $display("FAIL t2_drain got %b want 1", d); end
        cmp_cnt++; if (tx_log.size() !== 4) begin err_cnt++; $display("FAIL t2_count got %0d want 4", tx_log.size()); end
        for (int k = 0; k < 4; k++) begin
            cmp_cnt++;
            if (k >= tx_log.size() || tx_log[k] !== exp[k]) begin
                err_cnt++; $display("FAIL t2_byte%0d got %h want %h", k, (k < tx_log.size()) ? tx_log[k] : 8'hxx, exp[k]);
            end
        end
        cmp_cnt++; if (rdy_err !== 0) begin err_cnt++; $display("FAIL t2_req1_ready_early got %0d want 0", rdy_err); end
        cmp_cnt++; if (lock_err !== 0) begin err_cnt++; $display("FAIL t2_lock_after_last got %0d want 0", lock_err); end
    endtask

    task automatic test_round_robin();
        bit d;
        logic [1:0] expg [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [7:0] expd [6] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41};
        do_reset();
        sq[0] = '{9'h130, 9'h140};
        sq[1] = '{9'h131, 9'h141};
        sq[2] = '{9'h132};
        sq[3] = '{9'h133};
        run_streams(3000, 1'b1, d);
        cmp_cnt++; if (d !== 1'b1) begin err_cnt++; $display("FAIL t3_drain got %b want 1", d); end
        cmp_cnt++; if (grant_log.size() !== 6) begin err_cnt++; $display("FAIL t3_grants got %0d want 6", grant_log.size()); end
        for (int k = 0; k < 6; k++) begin
            cmp_cnt++;
            if (k >= grant_log.size() || grant_log[k] !== expg[k]) begin
                err_cnt++; $display("FAIL t3_grant%0d got %0d want %0d", k, (k < grant_log.size()) ? grant_log[k] : 2'bxx, expg[k]);
            end
            cmp_cnt++;
            if (k >= tx_log.size() || tx_log[k] !== expd[k]) begin
                err_cnt++; $display("FAIL t3_byte%0d got %h want %h", k, (k < tx_log.size()) ? tx_log[k] : 8'hxx, expd[k]);
            end
        end
        cmp_cnt++; if (pulse_err + busy_err + rdy_err !== 0) begin err_cnt++; $display("FAIL t3_protocol got %0d want 0", pulse_err + busy_err + rdy_err); end
    endtask

    task automatic test_timeout();
        bit d;
        bit acc;
        int wcyc;
        do_reset();
        @(negedge clk);
        bus.req_valid[1] = 1'b1; bus.req_data[1] = 8'h55; bus.req_last[1] = 1'b0;
        acc = 1'b0;
        for (int c = 0; c < 20 && !acc; c++) begin
            #1 acc = bus.req_ready[1];
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        cmp_cnt++; if (acc !== 1'b1) begin err_cnt++; $display("FAIL t4_req1_accept got %b want 1", acc); end
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        bus.req_valid[2] = 1'b1; bus.req_data[2] = 8'h77; bus.req_last[2] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                cmp_cnt++; if (bus.tx_start !== 1'b1) begin err_cnt++; $display("FAIL t4_issue_latency got %b want 1", bus.tx_start); end
                cmp_cnt++; if (bus.tx_data !== 8'h55) begin err_cnt++; $display("FAIL t4_issue_data got %h want 55", bus.tx_data); end
            end
            if (k == 15) begin
                cmp_cnt++; if (locked !== 1'b1) begin err_cnt++; $display("FAIL t4_locked_at15 got %b want 1", locked); end
            end
            if (k == 16) begin
                cmp_cnt++; if (locked !== 1'b0) begin err_cnt++; $display("FAIL t4_locked_at16 got %b want 0", locked); end
            end
        end
        @(negedge clk);
        acc = 1'b0;
        wcyc = 0;
        for (int c = 0; c < 20 && !acc; c++) begin
            #1 acc = bus.req_ready[2];
            @(posedge clk);
            wcyc++;
            if (!acc) @(negedge clk);
        end
        #1;
        cmp_cnt++; if (wcyc !== 2) begin err_cnt++; $display("FAIL t4_req2_wait got %0d want 2", wcyc); end
        cmp_cnt++; if (grant_id !== 2'd2) begin err_cnt++; $display("FAIL t4_grant got %0d want 2", grant_id); end
        clear_inputs();
        run_streams(1000, 1'b1, d);
        cmp_cnt++; if (tx_log.size() !== 2 || tx_log[0] !== 8'h55 || tx_log[1] !== 8'h77) begin
            err_cnt++; $display("FAIL t4_tx got n=%0d want 55,77", tx_log.size());
        end
        cmp_cnt++; if (grant_log.size() !== 2 || grant_log[1] !== 2'd2) begin
            err_cnt++; $display("FAIL t4_grants got n=%0d want 1,2", grant_log.size());
        end
    endtask

    task automatic test_fifo_full();
        bit d;
        do_reset();
        @(posedge clk); #2 busy_force = 1'b1;
        sq[0] = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106};
        run_streams(30, 1'b0, d);
        cmp_cnt++; if (fifo_level !== 3'd4) begin err_cnt++; $display("FAIL t5_level got %0d want 4", fifo_level); end
        cmp_cnt++; if (bus.req_ready[0] !== 1'b0) begin err_cnt++; $display("FAIL t5_ready_full got %b want 0", bus.req_ready[0]); end
        cmp_cnt++; if (locked !== 1'b1) begin err_cnt++; $display("FAIL t5_no_timeout got %b want 1", locked); end
        cmp_cnt++; if (sq[0].size() !== 2) begin err_cnt++; $display("FAIL t5_pending got %0d want 2", sq[0].size()); end
        cmp_cnt++; if (tx_log.size() !== 0) begin err_cnt++; $display("FAIL t5_tx_while_busy got %0d want 0", tx_log.size()); end
        @(posedge clk); #2 busy_force = 1'b0;
        run_streams(3000, 1'b1, d);
        cmp_cnt++; if (tx_log.size() !== 6) begin err_cnt++; $display("FAIL t5_count got %0d want 6", tx_log.size()); end
        for (int k = 0; k < 6; k++) begin
            cmp_cnt++;
            if (k >= tx_log.size() || tx_log[k] !== 8'(k + 1)) begin
                err_cnt++; $display("FAIL t5_byte%0d got %h want %h", k, (k < tx_log.size()) ? tx_log[k] : 8'hxx, 8'(k + 1));
            end
        end
        cmp_cnt++; if (pulse_err + busy_err !== 0) begin err_cnt++; $display("FAIL t5_protocol got %0d want 0", pulse_err + busy_err); end
    endtask

    task automatic test_reset_mid_frame();
        bit d;
        do_reset();
        @(posedge clk); #2 busy_force = 1'b1;
        sq[0] = '{9'h0a1, 9'h0a2, 9'h0a3};
        run_streams(8, 1'b0, d);
        cmp_cnt++; if (fifo_level !== 3'd3) begin err_cnt++; $display("FAIL t6_pre_level got %0d want 3", fifo_level); end
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        cmp_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL t6_level got %0d want 0", fifo_level); end
        cmp_cnt++; if (locked !== 1'b0) begin err_cnt++; $display("FAIL t6_locked got %b want 0", locked); end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        run_streams(20, 1'b0, d);
        cmp_cnt++; if (tx_log.size() !== 0) begin err_cnt++; $display("FAIL t6_start_while_busy got %0d want 0", tx_log.size()); end
        @(posedge clk); #2 busy_force = 1'b0;
        run_streams(10, 1'b0, d);
        cmp_cnt++; if (tx_log.size() !== 0) begin err_cnt++; $display("FAIL t6_stale_bytes got %0d want 0", tx_log.size()); end
        sq[2] = '{9'h1b5};
        run_streams(500, 1'b1, d);
        cmp_cnt++; if (tx_log.size() !== 1 || tx_log[0] !== 8'hb5) begin
            err_cnt++; $display("FAIL t6_new_byte got n=%0d want 1 byte b5", tx_log.size());
        end
        cmp_cnt++; if (grant_log.size() !== 2 || grant_log[1] !== 2'd2) begin
            err_cnt++; $display("FAIL t6_grants got n=%0d want 0,2", grant_log.size());
        end
    endtask

    initial begin
        clear_inputs();
        #1 resetn = 1'b0;
        test_reset();
        test_single_packet();
        test_packet_lock();
        test_round_robin();
        test_timeout();
        test_fifo_full();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
